// File: rtl/alu_sequencer_pkg.sv
// Shared datapath package for the ALU sequencer: state encoding and
// instruction-code width.
package alu_sequencer_pkg;

  localparam int PC_W  = 3;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_PAUSE  = 3'd6
  } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// ALU instruction sequencer: steps a run of PROG_LEN instruction codes,
// starting at START_PC, through FETCH/DECODE/READ/EXEC/WB and drives the
// per-stage enables. Optional feature macro SEQ_SINGLE_STEP_EN adds a step
// input and a PAUSE state between instructions.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int PROG_LEN = 8,
  parameter int START_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hold,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] pc_out,
  output logic            dec_en,
  output logic            rd_en,
  output logic            alu_en,
  output logic            wb_en,
  output logic            busy,
  output logic            done,
  output logic [3:0]      instr_cnt
);

  localparam logic [PC_W-1:0]  START_CODE = PC_W'(START_PC);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(PROG_LEN);

  seq_state_t            state;
  logic [CNT_W-1:0]      cnt_next;

  assign cnt_next = instr_cnt + 4'd1;

  // Sequencer FSM, pc register and completed-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc_out    <= START_CODE;
      instr_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          state     <= S_FETCH;
          pc_out    <= START_CODE;
          instr_cnt <= '0;
        end
      end else if (!hold) begin
        case (state)
          S_FETCH:  state <= S_DECODE;
          S_DECODE: state <= S_READ;
          S_READ:   state <= S_EXEC;
          S_EXEC:   state <= S_WB;
          S_WB: begin
            instr_cnt <= cnt_next;
            if (cnt_next == LAST_CNT) begin
              state  <= S_IDLE;
              pc_out <= START_CODE;
              done   <= 1'b1;
            end else begin
              pc_out <= pc_out + 3'd1;
`ifdef SEQ_SINGLE_STEP_EN
              state  <= S_PAUSE;
`else
              state  <= S_FETCH;
`endif
            end
          end
`ifdef SEQ_SINGLE_STEP_EN
          S_PAUSE: if (step) state <= S_FETCH;
`endif
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

  // Stage enables follow the registered state and drop while stalled.
  always_comb begin
    busy   = (state != S_IDLE);
    dec_en = (state == S_DECODE) && !hold;
    rd_en  = (state == S_READ)   && !hold;
    alu_en = (state == S_EXEC)   && !hold;
    wb_en  = (state == S_WB)     && !hold;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: two instances (default parameters
// and PROG_LEN=3/START_PC=6) compared every cycle against a counter-based
// behavioural model, plus directed literal expectations.
module tb_alu_sequencer;

`ifdef SEQ_SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, hold, step;
  always #5 clk = ~clk;

  logic [2:0] pc0, pc1;
  logic dec0, rd0, alu0, wb0, busy0, done0;
  logic dec1, rd1, alu1, wb1, busy1, done1;
  logic [3:0] cnt0, cnt1;

  alu_sequencer #(.PROG_LEN(8), .START_PC(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .pc_out(pc0), .dec_en(dec0), .rd_en(rd0), .alu_en(alu0), .wb_en(wb0),
    .busy(busy0), .done(done0), .instr_cnt(cnt0));

  alu_sequencer #(.PROG_LEN(3), .START_PC(6)) u1 (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .pc_out(pc1), .dec_en(dec1), .rd_en(rd1), .alu_en(alu1), .wb_en(wb1),
    .busy(busy1), .done(done1), .instr_cnt(cnt1));

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: run flag, instruction index, phase within the
  // instruction (0..4 = fetch..writeback, 5 = waiting for step).
  int pl [2] = '{8, 3};
  int sp [2] = '{0, 6};
  int m_act [2], m_k [2], m_ph [2], m_cnt [2], m_done [2];

  task automatic model_step(input int i);
    if (rst) begin
      m_act[i] = 0; m_k[i] = 0; m_ph[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
    end else if (m_act[i] == 0) begin
      m_done[i] = 0;
      if (start) begin
        m_act[i] = 1; m_k[i] = 0; m_ph[i] = 0; m_cnt[i] = 0;
      end
    end else if (hold) begin
      m_done[i] = 0;
    end else if (m_ph[i] < 4) begin
      m_ph[i]++;
    end else if (m_ph[i] == 4) begin
      m_cnt[i]++;
      if (m_cnt[i] == pl[i]) begin
        m_act[i] = 0; m_done[i] = 1; m_k[i] = 0; m_ph[i] = 0;
      end else begin
        m_k[i]++;
        m_ph[i] = STEP_EN ? 5 : 0;
      end
    end else if (step) begin
      m_ph[i] = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_k[i] = 0; m_ph[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
    end
  end

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cmp(input int i, input int pc, input int de, input int re,
                     input int ae, input int we, input int bz, input int dn,
                     input int ct);
    int on;
    on = (m_act[i] != 0) && !hold;
    chk($sformatf("i%0d pc_out", i), pc, m_act[i] ? (sp[i] + m_k[i]) % 8 : sp[i]);
    chk($sformatf("i%0d dec_en", i), de, on && m_ph[i] == 1);
    chk($sformatf("i%0d rd_en", i), re, on && m_ph[i] == 2);
    chk($sformatf("i%0d alu_en", i), ae, on && m_ph[i] == 3);
    chk($sformatf("i%0d wb_en", i), we, on && m_ph[i] == 4);
    chk($sformatf("i%0d busy", i), bz, m_act[i]);
    chk($sformatf("i%0d done", i), dn, m_done[i]);
    chk($sformatf("i%0d instr_cnt", i), ct, m_cnt[i]);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp(0, pc0, dec0, rd0, alu0, wb0, busy0, done0, cnt0);
      cmp(1, pc1, dec1, rd1, alu1, wb1, busy1, done1, cnt1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int b0, w0, d0, b1, npc, pcd1, abad, a13;
    int pcs1 [3];
    int dl0 [3];
    int dl1 [2];
    int nd0, nd1;
    rst = 1'b1; start = 1'b0; hold = 1'b0; step = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("reset pc0", pc0, 0);
    chk("reset pc1", pc1, 6);
    chk("reset busy0", busy0, 0);
    chk("reset cnt1", cnt1, 0);
    chk("reset done0", done0, 0);
    cyc();

`ifndef SEQ_SINGLE_STEP_EN
    // Plain run on both instances.
    pulse_start();
    b0 = 0; w0 = 0; d0 = 0; b1 = 0; npc = 0; pcd1 = -1;
    for (int c = 1; c <= 60 && d0 == 0; c++) begin
      @(negedge clk);
      if (busy0) b0++;
      if (wb0) w0++;
      if (done0) d0 = c;
      if (busy1) b1++;
      if (wb1 && npc < 3) begin pcs1[npc] = pc1; npc++; end
      if (done1 && pcd1 < 0) pcd1 = pc1;
    end
    chk("run busy cycles", b0, 40);
    chk("run wb count", w0, 8);
    chk("run done cycle", d0, 41);
    chk("run final cnt", cnt0, 8);
    chk("short busy cycles", b1, 15);
    chk("short wb count", npc, 3);
    chk("short pc first", pcs1[0], 6);
    chk("short pc second", pcs1[1], 7);
    chk("short pc wrap", pcs1[2], 0);
    chk("short pc at done", pcd1, 6);
    cyc();

    // Four-cycle stall on EXEC of the second instruction.
    pulse_start();
    b0 = 0; d0 = 0; abad = 0; a13 = 0;
    for (int c = 1; c <= 80 && d0 == 0; c++) begin
      hold = (c >= 9 && c <= 12);
      @(negedge clk);
      if (busy0) b0++;
      if (c >= 9 && c <= 12 && alu0) abad++;
      if (c == 13) a13 = alu0;
      if (done0) d0 = c;
      cyc();
    end
    hold = 1'b0;
    chk("hold busy cycles", b0, 44);
    chk("hold alu low", abad, 0);
    chk("hold alu resume", a13, 1);
    chk("hold done cycle", d0, 45);

    // Reset during READ of the fifth instruction.
    pulse_start();
    for (int c = 1; c <= 24; c++) begin
      rst = (c == 23);
      @(negedge clk);
      if (c == 23) begin
        chk("pre-rst rd_en", rd0, 1);
        chk("pre-rst cnt", cnt0, 4);
        chk("pre-rst pc", pc0, 4);
      end
      if (c == 24) begin
        chk("post-rst busy", busy0, 0);
        chk("post-rst pc", pc0, 0);
        chk("post-rst cnt", cnt0, 0);
        chk("post-rst enables", {dec0, rd0, alu0, wb0, done0}, 0);
      end
      cyc();
    end
    rst = 1'b0;

    // Start held high: back-to-back runs.
    start = 1'b1;
    nd0 = 0; nd1 = 0;
    for (int c = 1; c <= 130; c++) begin
      @(negedge clk);
      if (done0 && nd0 < 3) begin dl0[nd0] = c; nd0++; end
      if (done1 && nd1 < 2) begin dl1[nd1] = c; nd1++; end
      cyc();
    end
    start = 1'b0;
    chk("b2b done count", nd0, 3);
    chk("b2b period a", dl0[1] - dl0[0], 41);
    chk("b2b period b", dl0[2] - dl0[1], 41);
    chk("b2b short period", dl1[1] - dl1[0], 16);
    for (int c = 0; c < 50; c++) cyc();
`endif

    // Randomized traffic checked by the model on every cycle.
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 4) == 0);
      step  = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      cyc();
    end
    rst = 1'b1; start = 1'b0; hold = 1'b0; step = 1'b0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("final reset busy1", busy1, 0);
    chk("final reset pc1", pc1, 6);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
